// File: rtl/ws_stream_rx_pkg.sv
// Shared constants and state encoding for the LED-chain pulse-width link.
// The serializer and the receiver both build on these defaults.
package ws_pkg;

  localparam int WS_BIT_THRESH = 60;
  localparam int WS_MIN_HIGH   = 10;
  localparam int WS_MAX_HIGH   = 110;
  localparam int WS_GAP_CYCLES = 150;
  localparam int WS_WORD_BITS  = 24;
  localparam int WS_BIT_PERIOD = 125;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_IDLE = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } ws_state_e;

endpackage

// File: rtl/ws_rx_sync.sv
// Two-flop synchronizer for the serial line plus single-cycle rise/fall pulses
// derived from the synchronized value and its one-cycle-old copy.
module ws_rx_sync (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_din,
  output logic o_ds,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_din;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_ds   = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/ws_stream_rx.sv
// Pulse-width decoder for the LED chain: classifies high pulses into bits,
// packs 24-bit words and emits them on an AXI-stream master with frame tlast.
module ws_stream_rx
  import ws_pkg::*;
#(
  parameter int BIT_THRESH = WS_BIT_THRESH,
  parameter int MIN_HIGH   = WS_MIN_HIGH,
  parameter int MAX_HIGH   = WS_MAX_HIGH,
  parameter int GAP_CYCLES = WS_GAP_CYCLES,
  parameter int CNT_W      = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        din,
  output logic [23:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        frame_err,
  output logic        overflow,
  input  logic        clear_err,
  output ws_state_e   o_dbg_state
);

  localparam logic [CNT_W-1:0] LP_THRESH = CNT_W'(BIT_THRESH);
  localparam logic [CNT_W-1:0] LP_MIN    = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] LP_MAX    = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] LP_GAP    = CNT_W'(GAP_CYCLES);
  localparam logic [4:0]       LP_LAST_BIT = 5'(WS_WORD_BITS - 1);

  logic w_ds;
  logic w_rise;
  logic w_fall;

  ws_rx_sync u_sync (
    .i_clk  (clock),
    .i_rstn (resetn),
    .i_din  (din),
    .o_ds   (w_ds),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  ws_state_e        r_state;
  logic [CNT_W-1:0] r_low_cnt;
  logic [CNT_W-1:0] r_high_cnt;
  logic [4:0]       r_bit_cnt;
  logic [23:0]      r_shift;
  logic [23:0]      r_pend_data;
  logic             r_pend_valid;
  logic [23:0]      r_out_data;
  logic             r_out_valid;
  logic             r_out_last;
  logic             r_frame_err;
  logic             r_overflow;

  logic [CNT_W-1:0] w_hc_inc;
  logic [CNT_W-1:0] w_lc_inc;
  logic             w_bit;
  logic             w_bad_pulse;
  logic             w_err;
  logic             w_bit_ok;
  logic             w_word_done;
  logic             w_gap_end;
  logic [23:0]      w_word;
  logic             w_push;
  logic             w_push_last;
  logic             w_set_frame_err;
  logic             w_load;

  // Event decode: every word movement out of the FSM goes through w_push.
  always_comb begin
    w_hc_inc        = (&r_high_cnt) ? r_high_cnt : r_high_cnt + 1'b1;
    w_lc_inc        = (&r_low_cnt) ? r_low_cnt : r_low_cnt + 1'b1;
    w_bit           = (r_high_cnt >= LP_THRESH);
    w_bad_pulse     = (r_high_cnt < LP_MIN) || (r_high_cnt > LP_MAX);
    w_err           = 1'b0;
    w_bit_ok        = 1'b0;
    w_gap_end       = 1'b0;
    if (r_state == ST_HIGH) begin
      w_err    = w_fall ? w_bad_pulse : (r_high_cnt > LP_MAX);
      w_bit_ok = w_fall && !w_bad_pulse;
    end
    if (r_state == ST_LOW) begin
      w_gap_end = !w_rise && (w_lc_inc >= LP_GAP);
    end
    w_word_done     = w_bit_ok && (r_bit_cnt == LP_LAST_BIT);
    w_word          = r_shift;
    w_word[r_bit_cnt] = w_bit;
    w_push          = 1'b0;
    w_push_last     = 1'b0;
    if (w_word_done && r_pend_valid) begin
      w_push      = 1'b1;
      w_push_last = 1'b0;
    end else if ((w_gap_end || w_err) && r_pend_valid) begin
      w_push      = 1'b1;
      w_push_last = 1'b1;
    end
    w_set_frame_err = w_err || (w_gap_end && (r_bit_cnt != 5'd0));
    w_load          = w_push && (!r_out_valid || m_tready);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state      <= ST_HUNT;
      r_low_cnt    <= '0;
      r_high_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_pend_data  <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_HUNT: begin
          r_bit_cnt <= '0;
          r_shift   <= '0;
          if (w_ds) begin
            r_low_cnt <= '0;
          end else if (w_lc_inc >= LP_GAP) begin
            r_low_cnt <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_low_cnt <= w_lc_inc;
          end
        end
        ST_IDLE: begin
          r_bit_cnt <= '0;
          if (w_rise) begin
            r_high_cnt <= CNT_W'(1);
            r_state    <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (w_err) begin
            // Partial word is abandoned; any pending word was pushed above.
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_pend_valid <= 1'b0;
            r_low_cnt    <= '0;
            r_state      <= ST_HUNT;
          end else if (w_fall) begin
            r_low_cnt <= CNT_W'(1);
            r_state   <= ST_LOW;
            if (w_word_done) begin
              r_pend_data  <= w_word;
              r_pend_valid <= 1'b1;
              r_bit_cnt    <= '0;
              r_shift      <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
              r_shift   <= w_word;
            end
          end else begin
            r_high_cnt <= w_hc_inc;
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            r_high_cnt <= CNT_W'(1);
            r_state    <= ST_HIGH;
          end else if (w_gap_end) begin
            r_pend_valid <= 1'b0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_low_cnt    <= '0;
            r_state      <= ST_IDLE;
          end else begin
            r_low_cnt <= w_lc_inc;
          end
        end
        default: r_state <= ST_HUNT;
      endcase
    end
  end

  // Stream handshake: a beat transfers on a clock edge where m_tvalid and
  // m_tready are both high; data and last are held until that happens and
  // are only rewritten on a load, so an unaccepted word is never replaced.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_data  <= r_pend_data;
        r_out_last  <= w_push_last;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && m_tready) begin
        r_out_valid <= 1'b0;
      end
      if (w_set_frame_err) begin
        r_frame_err <= 1'b1;
      end else if (clear_err) begin
        r_frame_err <= 1'b0;
      end
      if (w_push && !w_load) begin
        r_overflow <= 1'b1;
      end else if (clear_err) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign m_tdata     = r_out_data;
  assign m_tvalid    = r_out_valid;
  assign m_tlast     = r_out_last;
  assign frame_err   = r_frame_err;
  assign overflow    = r_overflow;
  assign o_dbg_state = r_state;

endmodule
